// File: rtl/uplink_tx_arbiter.sv
// Frame-granular arbiter for the uplink UART TX FIFO: S has strict priority, A/B alternate; stuck frames are aborted after GAP_CYC idle cycles.
// Byte accepted -> tdr/tf_push one cycle later; *_ready low while FIFO near full or a push is in flight. Option: `TXARB_FRAME_CNT_EN.
module uplink_tx_arbiter #(
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_W      = 5,
  parameter int GAP_CYC    = 5000,
  parameter int GUARD_CYC  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       a_data,
  input  logic             a_valid,
  input  logic             a_last,
  output logic             a_ready,
  input  logic [7:0]       b_data,
  input  logic             b_valid,
  input  logic             b_last,
  output logic             b_ready,
  input  logic [7:0]       s_data,
  input  logic             s_valid,
  input  logic             s_last,
  output logic             s_ready,
  input  logic [CNT_W-1:0] tf_counter,
  output logic [7:0]       tdr,
  output logic             tf_push,
  output logic [1:0]       grant,
  output logic             abort,
  output logic [15:0]      fcnt_a,
  output logic [15:0]      fcnt_b,
  output logic [15:0]      fcnt_s
);

  localparam int TMR_W = $clog2(GAP_CYC + 1);
  localparam int GRD_W = $clog2(GUARD_CYC + 1);

  localparam logic [CNT_W-1:0] PUSH_MAX = CNT_W'(FIFO_DEPTH - 2);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(GAP_CYC - 1);
  localparam logic [GRD_W-1:0] GRD_LAST = GRD_W'(GUARD_CYC - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_XFER  = 2'd1;
  localparam logic [1:0] ST_GUARD = 2'd2;

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_A    = 2'b01;
  localparam logic [1:0] GNT_B    = 2'b10;
  localparam logic [1:0] GNT_S    = 2'b11;

  logic [1:0]       state;
  logic [TMR_W-1:0] idle_tmr;
  logic [GRD_W-1:0] guard_cnt;
  logic             rr_last_b;

  logic       sel_valid;
  logic       sel_last;
  logic [7:0] sel_data;
  logic       fifo_room;
  logic       accept;
  logic       tmr_expire;
  logic [1:0] arb_pick;

  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = 8'h00;
    case (grant)
      GNT_A: begin
        sel_valid = a_valid;
        sel_last  = a_last;
        sel_data  = a_data;
      end
      GNT_B: begin
        sel_valid = b_valid;
        sel_last  = b_last;
        sel_data  = b_data;
      end
      GNT_S: begin
        sel_valid = s_valid;
        sel_last  = s_last;
        sel_data  = s_data;
      end
      default: ;
    endcase
  end

  // Holding off while tf_push is high caps the rate at one byte per two cycles,
  // so tf_counter always reflects every byte already pushed.
  assign fifo_room  = (tf_counter <= PUSH_MAX);
  assign accept     = (state == ST_XFER) && sel_valid && fifo_room && !tf_push;
  assign tmr_expire = (idle_tmr == TMR_LAST);

  assign a_ready = accept && (grant == GNT_A);
  assign b_ready = accept && (grant == GNT_B);
  assign s_ready = accept && (grant == GNT_S);

  always_comb begin
    arb_pick = GNT_NONE;
    if (s_valid) begin
      arb_pick = GNT_S;
    end else if (a_valid && b_valid) begin
      arb_pick = rr_last_b ? GNT_A : GNT_B;
    end else if (a_valid) begin
      arb_pick = GNT_A;
    end else if (b_valid) begin
      arb_pick = GNT_B;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      grant     <= GNT_NONE;
      tdr       <= 8'h00;
      tf_push   <= 1'b0;
      abort     <= 1'b0;
      rr_last_b <= 1'b1;
      idle_tmr  <= '0;
      guard_cnt <= '0;
    end else begin
      tf_push <= accept;
      abort   <= 1'b0;
      if (accept) begin
        tdr <= sel_data;
      end
      case (state)
        ST_IDLE: begin
          idle_tmr  <= '0;
          guard_cnt <= '0;
          if (arb_pick != GNT_NONE) begin
            grant <= arb_pick;
            state <= ST_XFER;
          end
        end
        ST_XFER: begin
          if (accept) begin
            idle_tmr <= '0;
            if (sel_last) begin
              state     <= ST_GUARD;
              grant     <= GNT_NONE;
              guard_cnt <= '0;
              if (grant == GNT_A) rr_last_b <= 1'b0;
              if (grant == GNT_B) rr_last_b <= 1'b1;
            end
          end else if (tmr_expire) begin
            // An aborted A/B source still counts as served, so it loses the next tie.
            abort     <= 1'b1;
            state     <= ST_GUARD;
            grant     <= GNT_NONE;
            guard_cnt <= '0;
            idle_tmr  <= '0;
            if (grant == GNT_A) rr_last_b <= 1'b0;
            if (grant == GNT_B) rr_last_b <= 1'b1;
          end else begin
            idle_tmr <= idle_tmr + TMR_W'(1);
          end
        end
        ST_GUARD: begin
          grant <= GNT_NONE;
          if (guard_cnt == GRD_LAST) begin
            state <= ST_IDLE;
          end else begin
            guard_cnt <= guard_cnt + GRD_W'(1);
          end
        end
        default: begin
          state <= ST_IDLE;
          grant <= GNT_NONE;
        end
      endcase
    end
  end

`ifdef TXARB_FRAME_CNT_EN
  logic frame_done;
  assign frame_done = accept && sel_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fcnt_a <= 16'h0000;
      fcnt_b <= 16'h0000;
      fcnt_s <= 16'h0000;
    end else if (frame_done) begin
      case (grant)
        GNT_A:   fcnt_a <= fcnt_a + 16'd1;
        GNT_B:   fcnt_b <= fcnt_b + 16'd1;
        GNT_S:   fcnt_s <= fcnt_s + 16'd1;
        default: ;
      endcase
    end
  end
`else
  assign fcnt_a = 16'h0000;
  assign fcnt_b = 16'h0000;
  assign fcnt_s = 16'h0000;
`endif

endmodule

// File: tb/tb_uplink_tx_arbiter.sv
// Bench for uplink_tx_arbiter: directed scenarios plus randomized frames checked against a frame-order model.
module tb_uplink_tx_arbiter;

  localparam int GAP   = 5000;
  localparam int GUARD = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  a_data, b_data, s_data;
  logic        a_valid, b_valid, s_valid;
  logic        a_last, b_last, s_last;
  logic        a_ready, b_ready, s_ready;
  logic [4:0]  tf_counter;
  logic [7:0]  tdr;
  logic        tf_push;
  logic [1:0]  grant;
  logic        abort;
  logic [15:0] fcnt_a, fcnt_b, fcnt_s;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  uplink_tx_arbiter #(
    .FIFO_DEPTH(16), .CNT_W(5), .GAP_CYC(GAP), .GUARD_CYC(GUARD)
  ) dut (
    .clk(clk), .rst(rst),
    .a_data(a_data), .a_valid(a_valid), .a_last(a_last), .a_ready(a_ready),
    .b_data(b_data), .b_valid(b_valid), .b_last(b_last), .b_ready(b_ready),
    .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
    .tf_counter(tf_counter), .tdr(tdr), .tf_push(tf_push), .grant(grant),
    .abort(abort), .fcnt_a(fcnt_a), .fcnt_b(fcnt_b), .fcnt_s(fcnt_s)
  );

  // Observation of the DUT, owned by this process only.
  int          cyc = 0;
  logic [7:0]  push_q[$];
  int          acc_src_q[$];
  logic [7:0]  acc_dat_q[$];
  int          acc_cyc_q[$];
  int          mon_viol = 0;
  int          abort_cnt = 0;
  bit          prev_push = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      if (tf_push) push_q.push_back(tdr);
      if (tf_push && prev_push) mon_viol++;
      if (int'(a_ready) + int'(b_ready) + int'(s_ready) > 1) mon_viol++;
      if ((a_ready && grant != 2'b01) || (b_ready && grant != 2'b10) ||
          (s_ready && grant != 2'b11)) mon_viol++;
      if (a_ready) begin acc_src_q.push_back(1); acc_dat_q.push_back(a_data); acc_cyc_q.push_back(cyc); end
      if (b_ready) begin acc_src_q.push_back(2); acc_dat_q.push_back(b_data); acc_cyc_q.push_back(cyc); end
      if (s_ready) begin acc_src_q.push_back(3); acc_dat_q.push_back(s_data); acc_cyc_q.push_back(cyc); end
      if (abort) abort_cnt++;
    end
    prev_push = tf_push;
  end

  // Source stimulus: index 0 = A, 1 = B, 2 = S (grant code = index + 1).
  logic [7:0] sd[3][$];
  bit         sl[3][$];
  int         start_dly[3];
  int         exp_src_q[$];
  logic [7:0] exp_dat_q[$];
  int         exp_fr[3];

  function automatic logic [15:0] fexp(input int n);
`ifdef TXARB_FRAME_CNT_EN
    return 16'(n);
`else
    return 16'(0 * n);
`endif
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    a_valid = 0; b_valid = 0; s_valid = 0;
    a_last = 0; b_last = 0; s_last = 0;
    a_data = 0; b_data = 0; s_data = 0;
    tf_counter = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic clear_sources();
    for (int s = 0; s < 3; s++) begin
      sd[s].delete(); sl[s].delete(); start_dly[s] = 0;
    end
  endtask

  task automatic add_frame(input int s, input int len);
    for (int k = 0; k < len; k++) begin
      sd[s].push_back(8'($urandom));
      sl[s].push_back(k == len - 1);
    end
  endtask

  // Frame-level model: S first whenever it has a frame, else A/B alternate starting from A.
  task automatic build_expect();
    int pos[3];
    int left[3];
    int rr;
    int pick;
    exp_src_q.delete(); exp_dat_q.delete();
    for (int s = 0; s < 3; s++) begin
      pos[s] = 0; left[s] = 0;
      foreach (sl[s][k]) if (sl[s][k]) left[s]++;
      exp_fr[s] = left[s];
    end
    rr = 1;
    while (left[0] + left[1] + left[2] > 0) begin
      if (left[2] > 0) pick = 2;
      else if (left[0] > 0 && left[1] > 0) pick = (rr == 1) ? 0 : 1;
      else if (left[0] > 0) pick = 0;
      else pick = 1;
      do begin
        exp_src_q.push_back(pick + 1);
        exp_dat_q.push_back(sd[pick][pos[pick]]);
        pos[pick]++;
      end while (!sl[pick][pos[pick]-1]);
      left[pick]--;
      if (pick < 2) rr = pick;
    end
  endtask

  task automatic run_sources(input int max_gap, input bit rand_full, input int budget);
    int idx[3];
    int gap[3];
    bit v[3];
    bit acc[3];
    int n;
    bit busy;
    n = 0;
    busy = 1'b1;
    for (int s = 0; s < 3; s++) begin idx[s] = 0; gap[s] = start_dly[s]; end
    while (busy && n < budget) begin
      for (int s = 0; s < 3; s++) v[s] = (idx[s] < sd[s].size()) && (gap[s] == 0);
      a_valid = v[0]; a_data = v[0] ? sd[0][idx[0]] : 8'h00; a_last = v[0] ? sl[0][idx[0]] : 1'b0;
      b_valid = v[1]; b_data = v[1] ? sd[1][idx[1]] : 8'h00; b_last = v[1] ? sl[1][idx[1]] : 1'b0;
      s_valid = v[2]; s_data = v[2] ? sd[2][idx[2]] : 8'h00; s_last = v[2] ? sl[2][idx[2]] : 1'b0;
      if (rand_full)
        tf_counter = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(15, 16)) : 5'($urandom_range(0, 14));
      @(negedge clk);
      acc[0] = a_valid && a_ready;
      acc[1] = b_valid && b_ready;
      acc[2] = s_valid && s_ready;
      @(posedge clk); #1;
      n++;
      busy = 1'b0;
      for (int s = 0; s < 3; s++) begin
        if (acc[s]) begin
          idx[s]++;
          gap[s] = (idx[s] < sd[s].size() && !sl[s][idx[s]-1]) ? int'($urandom_range(0, max_gap)) : 0;
        end else if (gap[s] > 0) begin
          gap[s]--;
        end
        if (idx[s] < sd[s].size()) busy = 1'b1;
      end
    end
    a_valid = 0; b_valid = 0; s_valid = 0; tf_counter = 0;
    checks++;
    if (busy) begin errors++; $display("FAIL run_sources_timeout cycles=%0d budget=%0d", n, budget); end
    repeat (GUARD + 8) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    a_valid = 1; b_valid = 1; s_valid = 1;
    a_last = 0; b_last = 0; s_last = 0;
    a_data = 8'hAA; b_data = 8'hBB; s_data = 8'hCC; tf_counter = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL reset_grant got=%b want=00", grant); end
    checks++; if (tf_push !== 1'b0) begin errors++; $display("FAIL reset_push got=%b want=0", tf_push); end
    checks++; if (tdr !== 8'h00) begin errors++; $display("FAIL reset_tdr got=%h want=00", tdr); end
    checks++; if (abort !== 1'b0) begin errors++; $display("FAIL reset_abort got=%b want=0", abort); end
    checks++; if ({a_ready, b_ready, s_ready} !== 3'b000) begin
      errors++; $display("FAIL reset_ready got=%b want=000", {a_ready, b_ready, s_ready}); end
    checks++; if ({fcnt_a, fcnt_b, fcnt_s} !== 48'h0) begin
      errors++; $display("FAIL reset_fcnt got=%h/%h/%h want=0", fcnt_a, fcnt_b, fcnt_s); end
    do_reset();
  endtask

  task automatic test_single_frame();
    logic [7:0] frame[8];
    int pb, ab, xb, bad;
    frame = '{8'hEB, 8'h90, 8'h5A, 8'hA5, 8'hC3, 8'h3C, 8'h09, 8'hD7};
    do_reset(); clear_sources();
    for (int k = 0; k < 8; k++) begin sd[0].push_back(frame[k]); sl[0].push_back(k == 7); end
    pb = push_q.size(); ab = acc_src_q.size(); xb = abort_cnt;
    run_sources(0, 1'b0, 500);
    checks++; if (push_q.size() - pb !== 8) begin
      errors++; $display("FAIL single_push_count got=%0d want=8", push_q.size() - pb); end
    else for (int k = 0; k < 8; k++) begin
      checks++; if (push_q[pb+k] !== frame[k]) begin
        errors++; $display("FAIL single_tdr[%0d] got=%h want=%h", k, push_q[pb+k], frame[k]); end
    end
    bad = 0;
    for (int k = ab; k < acc_src_q.size(); k++) if (acc_src_q[k] != 1) bad++;
    checks++; if (bad !== 0) begin errors++; $display("FAIL single_grant non_A_accepts=%0d want=0", bad); end
    checks++; if (abort_cnt - xb !== 0) begin errors++; $display("FAIL single_abort got=%0d want=0", abort_cnt - xb); end
    checks++; if (fcnt_a !== fexp(1)) begin errors++; $display("FAIL single_fcnt_a got=%0d want=%0d", fcnt_a, fexp(1)); end
  endtask

  task automatic test_round_robin();
    int ab;
    do_reset(); clear_sources();
    add_frame(0, 2); add_frame(0, 2); add_frame(1, 2); add_frame(1, 2);
    ab = acc_src_q.size();
    run_sources(0, 1'b0, 1000);
    build_expect();
    checks++; if (acc_src_q.size() - ab !== exp_src_q.size()) begin
      errors++; $display("FAIL rr_count got=%0d want=%0d", acc_src_q.size() - ab, exp_src_q.size()); end
    else begin
      checks++; if (acc_src_q[ab] !== 1) begin errors++; $display("FAIL rr_first got=%0d want=1", acc_src_q[ab]); end
      checks++; if (acc_src_q[ab+2] !== 2) begin errors++; $display("FAIL rr_second got=%0d want=2", acc_src_q[ab+2]); end
      for (int k = 0; k < exp_src_q.size(); k++) begin
        checks++; if (acc_src_q[ab+k] !== exp_src_q[k] || acc_dat_q[ab+k] !== exp_dat_q[k]) begin
          errors++; $display("FAIL rr_seq[%0d] got=%0d/%h want=%0d/%h", k, acc_src_q[ab+k], acc_dat_q[ab+k],
                             exp_src_q[k], exp_dat_q[k]); end
      end
    end
  endtask

  task automatic test_priority();
    int ab;
    do_reset(); clear_sources();
    add_frame(0, 6); add_frame(1, 3); add_frame(2, 2);
    start_dly[1] = 3; start_dly[2] = 3;
    ab = acc_src_q.size();
    run_sources(0, 1'b0, 1000);
    checks++; if (acc_src_q.size() - ab !== 11) begin
      errors++; $display("FAIL prio_count got=%0d want=11", acc_src_q.size() - ab); end
    else begin
      checks++; if (acc_src_q[ab+5] !== 1 || acc_src_q[ab+6] !== 3 || acc_src_q[ab+8] !== 2) begin
        errors++; $display("FAIL prio_order got=%0d,%0d,%0d want=1,3,2", acc_src_q[ab+5], acc_src_q[ab+6], acc_src_q[ab+8]); end
      checks++; if (acc_cyc_q[ab+6] - acc_cyc_q[ab+5] !== GUARD + 2) begin
        errors++; $display("FAIL prio_guard_gap got=%0d want=%0d", acc_cyc_q[ab+6] - acc_cyc_q[ab+5], GUARD + 2); end
    end
    checks++; if (fcnt_s !== fexp(1) || fcnt_b !== fexp(1)) begin
      errors++; $display("FAIL prio_fcnt got=%0d/%0d want=%0d", fcnt_s, fcnt_b, fexp(1)); end
  endtask

  task automatic test_fifo_full();
    int n, pb;
    do_reset();
    pb = push_q.size();
    tf_counter = 5'd15; a_data = 8'h11; a_last = 0; a_valid = 1;
    n = 0;
    do begin @(negedge clk); n++; end while (grant !== 2'b01 && n < 20);
    checks++; if (grant !== 2'b01) begin errors++; $display("FAIL full_grant got=%b want=01", grant); end
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      checks++; if (a_ready !== 1'b0 || tf_push !== 1'b0) begin
        errors++; $display("FAIL full_hold[%0d] ready=%b push=%b want=0/0", k, a_ready, tf_push); end
    end
    tf_counter = 5'd14;
    #1;
    checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL full_boundary14 ready=%b want=1", a_ready); end
    @(posedge clk); #1;
    a_data = 8'h22; a_last = 1; tf_counter = 5'd10;
    @(negedge clk);
    checks++; if (tf_push !== 1'b1 || tdr !== 8'h11) begin
      errors++; $display("FAIL full_push1 push=%b tdr=%h want=1/11", tf_push, tdr); end
    checks++; if (a_ready !== 1'b0) begin errors++; $display("FAIL full_spacing ready=%b want=0", a_ready); end
    @(negedge clk);
    checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL full_resume ready=%b want=1", a_ready); end
    @(posedge clk); #1;
    a_valid = 0; a_last = 0;
    @(negedge clk);
    checks++; if (tf_push !== 1'b1 || tdr !== 8'h22) begin
      errors++; $display("FAIL full_push2 push=%b tdr=%h want=1/22", tf_push, tdr); end
    repeat (3) @(negedge clk);
    checks++; if (push_q.size() - pb !== 2 || fcnt_a !== fexp(1)) begin
      errors++; $display("FAIL full_totals pushes=%0d fcnt_a=%0d want=2/%0d", push_q.size() - pb, fcnt_a, fexp(1)); end
  endtask

  task automatic test_abort();
    int n, pb, xb;
    bit to;
    do_reset();
    pb = push_q.size(); xb = abort_cnt; to = 0;
    a_valid = 1; a_last = 0;
    for (int k = 0; k < 3; k++) begin
      a_data = 8'h30 + 8'(k);
      n = 0;
      do begin @(negedge clk); n++; end while (!a_ready && n < 60);
      if (!a_ready) to = 1;
      @(posedge clk); #1;
    end
    checks++; if (to) begin errors++; $display("FAIL abort_setup handshake timeout=1 want=0"); end
    a_valid = 0;
    b_valid = 1; b_data = 8'hB0; b_last = 1;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!abort && n < GAP + 50);
    checks++; if (n !== GAP) begin errors++; $display("FAIL abort_time got=%0d want=%0d", n, GAP); end
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL abort_grant got=%b want=00", grant); end
    @(posedge clk); #1;
    checks++; if (abort !== 1'b0) begin errors++; $display("FAIL abort_pulse_width abort=%b want=0", abort); end
    checks++; if (push_q.size() - pb !== 3 || abort_cnt - xb !== 1) begin
      errors++; $display("FAIL abort_counts pushes=%0d aborts=%0d want=3/1", push_q.size() - pb, abort_cnt - xb); end
    checks++; if (fcnt_a !== 16'h0000) begin errors++; $display("FAIL abort_fcnt_a got=%0d want=0", fcnt_a); end
    a_valid = 1; a_data = 8'h40; a_last = 1;
    n = 0;
    do begin @(negedge clk); n++; end while (grant === 2'b00 && n < GUARD + 10);
    checks++; if (grant !== 2'b10) begin errors++; $display("FAIL abort_loses_tie got=%b want=10", grant); end
  endtask

  task automatic test_last_at_timeout();
    int n, pb, xb;
    do_reset();
    pb = push_q.size(); xb = abort_cnt;
    a_valid = 1; a_data = 8'h50; a_last = 0;
    n = 0;
    do begin @(negedge clk); n++; end while (!a_ready && n < 60);
    @(posedge clk); #1;
    a_valid = 0; a_data = 8'h51; a_last = 1;
    repeat (GAP - 1) @(posedge clk);
    #1 a_valid = 1;
    @(negedge clk);
    checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL lastto_ready got=%b want=1", a_ready); end
    @(posedge clk); #1;
    a_valid = 0; a_last = 0;
    repeat (4) @(negedge clk);
    checks++; if (abort_cnt - xb !== 0) begin errors++; $display("FAIL lastto_abort got=%0d want=0", abort_cnt - xb); end
    checks++; if (push_q.size() - pb !== 2 || fcnt_a !== fexp(1)) begin
      errors++; $display("FAIL lastto_totals pushes=%0d fcnt_a=%0d want=2/%0d", push_q.size() - pb, fcnt_a, fexp(1)); end
  endtask

  task automatic test_reset_mid_frame();
    int n;
    do_reset();
    a_valid = 1; a_last = 0;
    for (int k = 0; k < 3; k++) begin
      a_data = 8'h60 + 8'(k);
      n = 0;
      do begin @(negedge clk); n++; end while (!a_ready && n < 60);
      @(posedge clk); #1;
    end
    checks++; if (tf_push !== 1'b1 || grant !== 2'b01) begin
      errors++; $display("FAIL midrst_before push=%b grant=%b want=1/01", tf_push, grant); end
    rst = 1'b1;
    #1;
    checks++; if ({grant, tf_push, abort, a_ready} !== 5'b0 || tdr !== 8'h00) begin
      errors++; $display("FAIL midrst_outputs grant=%b push=%b abort=%b ready=%b tdr=%h want=0",
                         grant, tf_push, abort, a_ready, tdr); end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    a_data = 8'h6F; a_last = 1;
    n = 0;
    do begin @(negedge clk); n++; end while (grant === 2'b00 && n < 10);
    checks++; if (grant !== 2'b01 || fcnt_a !== 16'h0000) begin
      errors++; $display("FAIL midrst_rearb grant=%b fcnt_a=%0d want=01/0", grant, fcnt_a); end
    n = 0;
    while (!a_ready && n < 20) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    a_valid = 0; a_last = 0;
    repeat (3) @(negedge clk);
    checks++; if (fcnt_a !== fexp(1)) begin errors++; $display("FAIL midrst_fcnt_a got=%0d want=%0d", fcnt_a, fexp(1)); end
  endtask

  task automatic test_random();
    int ab, pb, xb, vb;
    for (int it = 0; it < 4; it++) begin
      do_reset(); clear_sources();
      for (int f = int'($urandom_range(0, 2)); f > 0; f--) add_frame(2, int'($urandom_range(1, 5)));
      for (int f = int'($urandom_range(1, 4)); f > 0; f--) add_frame(0, int'($urandom_range(1, 5)));
      for (int f = int'($urandom_range(1, 4)); f > 0; f--) add_frame(1, int'($urandom_range(1, 5)));
      ab = acc_src_q.size(); pb = push_q.size(); xb = abort_cnt; vb = mon_viol;
      run_sources(3, 1'b1, 20000);
      build_expect();
      checks++; if (acc_src_q.size() - ab !== exp_src_q.size() || push_q.size() - pb !== exp_dat_q.size()) begin
        errors++; $display("FAIL rand%0d_count acc=%0d push=%0d want=%0d", it, acc_src_q.size() - ab,
                           push_q.size() - pb, exp_src_q.size()); end
      else for (int k = 0; k < exp_src_q.size(); k++) begin
        checks++; if (acc_src_q[ab+k] !== exp_src_q[k] || push_q[pb+k] !== exp_dat_q[k]) begin
          errors++; $display("FAIL rand%0d_byte[%0d] got=%0d/%h want=%0d/%h", it, k, acc_src_q[ab+k],
                             push_q[pb+k], exp_src_q[k], exp_dat_q[k]); end
      end
      checks++; if (fcnt_a !== fexp(exp_fr[0]) || fcnt_b !== fexp(exp_fr[1]) || fcnt_s !== fexp(exp_fr[2])) begin
        errors++; $display("FAIL rand%0d_fcnt got=%0d/%0d/%0d want=%0d/%0d/%0d", it, fcnt_a, fcnt_b, fcnt_s,
                           fexp(exp_fr[0]), fexp(exp_fr[1]), fexp(exp_fr[2])); end
      checks++; if (abort_cnt - xb !== 0 || mon_viol - vb !== 0) begin
        errors++; $display("FAIL rand%0d_protocol aborts=%0d violations=%0d want=0/0", it, abort_cnt - xb, mon_viol - vb); end
    end
  endtask

  initial begin
    rst = 1'b1;
    clear_sources();
    test_reset();
    test_single_frame();
    test_round_robin();
    test_priority();
    test_fifo_full();
    test_abort();
    test_last_at_timeout();
    test_reset_mid_frame();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
